vhd_sd_arbiter: RTL and testbench
=================================

// Module: vhd_sd_arbiter
// PURPOSE
//  Shares the single hps_io virtual-disk channel (sd_rd/sd_wr/sd_lba/sd_ack/sd_buff_*) between two
//  sector requesters (0 = fixed-disk controller, 1 = floppy controller). Arbitrates round-robin,
//  sequences one 512-byte sector transaction at a time, and routes sd_buff traffic to the granted
//  requester. Adds a watchdog so a missing sd_ack cannot hang a requester.
// PARAMETERS
//  LBA_W        32        width of sector addresses
//  ACK_TIMEOUT  24'hFFFFFF clk_sys cycles to wait for sd_ack rise before aborting (>=2)
// PORTS
//  clk_sys       in   1      system clock; hps_io runs on the same clock
//  reset_n       in   1      asynchronous, active-low reset
//  req_rd        in   2      per-requester sector-read request, level, held until done/err
//  req_wr        in   2      per-requester sector-write request, level, held until done/err
//  req_lba0      in   LBA_W  sector address of requester 0
//  req_lba1      in   LBA_W  sector address of requester 1
//  req_din0      in   8      requester 0 write data for sd_buff_addr
//  req_din1      in   8      requester 1 write data for sd_buff_addr
//  grant         out  2      one-hot owner of the channel, 0 when idle
//  req_buff_wr   out  2      sd_buff_wr qualified by grant (read data strobe per requester)
//  req_done      out  2      1-cycle pulse: transaction completed
//  req_err       out  2      1-cycle pulse: transaction aborted by watchdog
//  sd_rd         out  1      to hps_io
//  sd_wr         out  1      to hps_io
//  sd_lba        out  LBA_W  to hps_io, latched at grant
//  sd_ack        in   1      from hps_io
//  sd_buff_wr    in   1      from hps_io
//  sd_buff_addr  in   9      from hps_io, unused internally except for muxing timing
//  sd_buff_dout  in   8      from hps_io; broadcast to both requesters outside this block
//  sd_buff_din   out  8      to hps_io: req_dinN of granted requester, 8'h00 when idle
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, all outputs 0, rr pointer=1 (requester 0 wins first tie),
//   watchdog=0. Reset mid-transaction aborts silently: no done/err pulse.
//  States: IDLE -> REQ -> XFER -> DONE -> GAP -> IDLE; REQ -> ABORT -> GAP on timeout.
//  IDLE: pending[i] = req_rd[i]|req_wr[i]. One pending -> grant it. Both -> grant the one != rr.
//   On grant (registered, 1 cycle after request seen): grant[i]=1, sd_lba<=req_lbaI,
//   sd_rd<=req_rd[i], sd_wr<=req_wr[i]&~req_rd[i] (rd wins if both set), rr<=i, watchdog<=0. -> REQ.
//  REQ: hold sd_rd/sd_wr; watchdog+1 per cycle. sd_ack=1 -> drop sd_rd/sd_wr next edge, -> XFER.
//   watchdog==ACK_TIMEOUT-1 without ack -> drop sd_rd/sd_wr, -> ABORT.
//  XFER: req_buff_wr = {2{sd_buff_wr}} & grant (combinational); sd_buff_din muxed by grant
//   (combinational). sd_ack=0 -> DONE. No timeout in XFER.
//  DONE: req_done[i]=1 for exactly 1 cycle, grant cleared. -> GAP.
//  ABORT: req_err[i]=1 for exactly 1 cycle, grant cleared. -> GAP.
//  GAP: 1 cycle; requester just served is masked so its still-high level request is not re-granted;
//   requester must drop req_rd/req_wr on the cycle after the done/err pulse. -> IDLE.
//  Request changes (lba, rd/wr) after grant are ignored until GAP. Request dropped during REQ/XFER
//   does not abort; transaction completes and done is pulsed.
//  Throughput: back-to-back requests from other requester granted 2 cycles after done pulse.
//  Watchdog: counter width $clog2(ACK_TIMEOUT+1), saturates, cleared on every grant.
// TESTING
//  1. req_rd=01, lba0=32'h10; ack rises 3 cyc after sd_rd, high 512 buff_wr -> sd_rd 1 cyc after req,
//     sd_lba=0x10, req_buff_wr[0] 512 pulses, [1] none, req_done=01 one cycle after ack fall.
//  2. req_wr=11 same cycle after reset -> requester 0 served first, then 1 (rr); sd_wr each time,
//     sd_buff_din tracks req_din0 then req_din1; done pulses 01 then 10.
//  3. Requester 0 keeps requesting continuously with 1 pending -> grants alternate 0,1,0,1.
//  4. ACK_TIMEOUT=16, never ack -> sd_rd high exactly 16 cycles, req_err=01 one cycle, no done.
//  5. reset_n low during XFER -> all outputs 0 immediately (async), no done/err; next req served.
//  6. req_rd=req_wr=1 on requester 1 -> sd_rd=1, sd_wr=0.

Source files
------------

// File: rtl/vhd_sd_arbiter_if.sv
// vhd_sd_arbiter_if: requester and hps_io virtual-disk signals shared by the two sector requesters.
interface vhd_sd_arbiter_if #(parameter int LBA_W = 32);
  logic [1:0]       req_rd, req_wr, grant, req_buff_wr, req_done, req_err;
  logic [LBA_W-1:0] req_lba0, req_lba1, sd_lba;
  logic [7:0]       req_din0, req_din1, sd_buff_dout, sd_buff_din;
  logic             sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [8:0]       sd_buff_addr;
  modport master (
    input  req_rd, req_wr, req_lba0, req_lba1, req_din0, req_din1,
           sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout,
    output grant, req_buff_wr, req_done, req_err, sd_rd, sd_wr, sd_lba, sd_buff_din
  );
  modport slave (
    output req_rd, req_wr, req_lba0, req_lba1, req_din0, req_din1,
           sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout,
    input  grant, req_buff_wr, req_done, req_err, sd_rd, sd_wr, sd_lba, sd_buff_din
  );
endinterface

// File: rtl/vhd_sd_arbiter.sv
// vhd_sd_arbiter: round-robin sharing of one hps_io sector channel between two requesters, with ack watchdog.
module vhd_sd_arbiter #(
  parameter int LBA_W       = 32,
  parameter int ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic clk_sys,
  input  logic reset_n,
  vhd_sd_arbiter_if.master bus
);
  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, ABORT, GAP} state_t;
  state_t           state_q;
  logic [1:0]       grant_q, done_q, err_q, pend;
  logic             sd_rd_q, sd_wr_q, rr_q, sel;
  logic [LBA_W-1:0] sd_lba_q;
  logic [WD_W-1:0]  wd_q;
  logic             unused_ok;
  assign pend = bus.req_rd | bus.req_wr;
  // rr_q holds the last requester served; on a tie the other one wins
  assign sel = &pend ? ~rr_q : pend[1];
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
      sd_lba_q <= '0;
      rr_q     <= 1'b1;
      wd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (|pend) begin
          grant_q  <= sel ? 2'b10 : 2'b01;
          sd_lba_q <= sel ? bus.req_lba1 : bus.req_lba0;
          sd_rd_q  <= bus.req_rd[sel];
          sd_wr_q  <= bus.req_wr[sel] & ~bus.req_rd[sel];
          rr_q     <= sel;
          wd_q     <= '0;
          state_q  <= REQ;
        end
        REQ: if (bus.sd_ack) begin
          sd_rd_q <= 1'b0;
          sd_wr_q <= 1'b0;
          state_q <= XFER;
        end else if (wd_q == WD_LAST) begin
          sd_rd_q <= 1'b0;
          sd_wr_q <= 1'b0;
          err_q   <= grant_q;
          grant_q <= '0;
          state_q <= ABORT;
        end else if (wd_q != '1) begin
          wd_q <= wd_q + 1'b1;
        end
        XFER: if (!bus.sd_ack) begin
          done_q  <= grant_q;
          grant_q <= '0;
          state_q <= DONE;
        end
        DONE, ABORT: begin
          done_q  <= '0;
          err_q   <= '0;
          state_q <= GAP;
        end
        // no arbitration here, so the requester just served cannot be re-granted on its stale level
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.grant       = grant_q;
  assign bus.req_done    = done_q;
  assign bus.req_err     = err_q;
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.sd_lba      = sd_lba_q;
  assign bus.req_buff_wr = {2{bus.sd_buff_wr}} & grant_q;
  assign bus.sd_buff_din = grant_q[0] ? bus.req_din0 : grant_q[1] ? bus.req_din1 : 8'h00;
  assign unused_ok       = ^{bus.sd_buff_addr, bus.sd_buff_dout};
endmodule

// File: tb/tb_vhd_sd_arbiter.sv
// tb_vhd_sd_arbiter: randomized rounds against a service-order model, scoreboard monitor, hps_io emulator.
module tb_vhd_sd_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, reset_n = 1'b1;
  always #5 clk = ~clk;
  vhd_sd_arbiter_if #(.LBA_W(32)) bus ();
  vhd_sd_arbiter #(.LBA_W(32), .ACK_TIMEOUT(TO)) dut (.clk_sys(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    bit who; logic [31:0] lba; bit rd; bit wr; bit err; int nbuf; logic [7:0] din;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0, failures = 0;
  bit rr_m = 1'b1;
  bit mode_ack[2];
  int nb[2], dly[2];
  bit active = 1'b0, pa = 1'b0, ppa = 1'b0;
  int hicnt = 0, bc0 = 0, bc1 = 0;
  logic [1:0] pg = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_rdwr"}, {bus.sd_rd, bus.sd_wr}, 0);
    chk({tag, "_lba"}, bus.sd_lba, 0);
    chk({tag, "_pulses"}, {bus.req_done, bus.req_err}, 0);
    chk({tag, "_buff_wr"}, bus.req_buff_wr, 0);
    chk({tag, "_din"}, bus.sd_buff_din, 0);
  endtask
  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      active = 1'b0; q.delete(); pa = 1'b0; ppa = 1'b0; pg = '0;
    end else begin
      if (pa) chk("ack_drop", {bus.sd_rd, bus.sd_wr}, 0);
      if (bus.grant != 0 && pg == 0) begin
        if (q.size() == 0) chk("unexpected_grant", bus.grant, 0);
        else begin
          cur = q.pop_front(); active = 1'b1; hicnt = 0; bc0 = 0; bc1 = 0;
          chk("grant", bus.grant, cur.who ? 2 : 1);
          chk("sd_rd", bus.sd_rd, cur.rd);
          chk("sd_wr", bus.sd_wr, cur.wr);
        end
      end
      if (bus.grant != 0 && active) begin
        chk("sd_lba", bus.sd_lba, cur.lba);
        chk("sd_buff_din", bus.sd_buff_din, cur.din);
      end
      if (bus.grant == 0) begin
        chk("idle_din", bus.sd_buff_din, 0);
        chk("idle_buff_wr", bus.req_buff_wr, 0);
      end
      if (bus.sd_rd || bus.sd_wr) hicnt++;
      bc0 += int'(bus.req_buff_wr[0]);
      bc1 += int'(bus.req_buff_wr[1]);
      if (bus.req_done != 0 || bus.req_err != 0) begin
        if (!active) chk("spurious_pulse", {bus.req_done, bus.req_err}, 0);
        else begin
          chk("req_done", bus.req_done, cur.err ? 0 : (cur.who ? 2 : 1));
          chk("req_err", bus.req_err, cur.err ? (cur.who ? 2 : 1) : 0);
          chk("grant_clear", bus.grant, 0);
          chk("buff_wr_own", cur.who ? bc1 : bc0, cur.nbuf);
          chk("buff_wr_other", cur.who ? bc0 : bc1, 0);
          if (cur.err) chk("rdwr_high_cycles", hicnt, TO);
          else chk("done_timing", {ppa, pa}, 2'b10);
          active = 1'b0;
        end
      end
      pg = bus.grant; ppa = pa; pa = bus.sd_ack;
    end
  end
  // hps_io emulator
  initial begin
    bus.sd_ack = 1'b0; bus.sd_buff_wr = 1'b0; bus.sd_buff_addr = '0; bus.sd_buff_dout = '0;
    forever begin
      tick;
      if (reset_n && (bus.sd_rd || bus.sd_wr)) begin
        automatic int w = int'(bus.grant[1]);
        automatic logic r = bus.sd_rd;
        if (mode_ack[w]) begin
          repeat (dly[w]) tick;
          bus.sd_ack = 1'b1;
          for (int k = 0; k < nb[w]; k++) begin
            bus.sd_buff_wr = r; bus.sd_buff_addr = 9'(k); bus.sd_buff_dout = 8'($urandom);
            tick;
          end
          bus.sd_buff_wr = 1'b0;
          tick;
          bus.sd_ack = 1'b0;
        end else while (bus.sd_rd || bus.sd_wr) tick;
      end
    end
  end
  task automatic round(input logic [1:0] pat, input logic [1:0] rd, input logic [1:0] wr,
                       input logic [1:0] ack, input int n, input logic [31:0] l0);
    logic [1:0] left;
    logic [31:0] l[2];
    logic [7:0] d[2];
    bit first;
    int cyc = 0;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      l[i] = $urandom; d[i] = 8'($urandom);
      mode_ack[i] = ack[i]; nb[i] = n; dly[i] = $urandom_range(0, 3);
    end
    l[0] = l0;
    first = (pat == 2'b11) ? ~rr_m : pat[1];
    for (int j = 0; j < ((pat == 2'b11) ? 2 : 1); j++) begin
      automatic bit w = (j != 0) ? ~first : first;
      e.who = w; e.lba = l[w]; e.rd = rd[w]; e.wr = wr[w] & ~rd[w]; e.err = ~ack[w];
      e.nbuf = (ack[w] && rd[w]) ? n : 0; e.din = d[w];
      q.push_back(e);
      rr_m = w;
    end
    bus.req_lba0 = l[0]; bus.req_lba1 = l[1]; bus.req_din0 = d[0]; bus.req_din1 = d[1];
    bus.req_rd = rd & pat; bus.req_wr = wr & pat;
    left = pat;
    while (left != 0 && cyc < 3000) begin
      tick; cyc++;
      for (int i = 0; i < 2; i++)
        if (bus.req_done[i] || bus.req_err[i]) begin
          left[i] = 1'b0; bus.req_rd[i] = 1'b0; bus.req_wr[i] = 1'b0;
        end
      // address changes after grant must not reach sd_lba
      if (bus.grant[0] && bus.sd_ack) bus.req_lba0 = $urandom;
      if (bus.grant[1] && bus.sd_ack) bus.req_lba1 = $urandom;
    end
    if (left != 0) begin
      chk("round_timeout", left, 0);
      bus.req_rd = '0; bus.req_wr = '0;
    end
    repeat ($urandom_range(0, 2)) tick;
  endtask
  task automatic reset_mid_xfer;
    int cyc = 0;
    exp_t e;
    mode_ack[0] = 1'b1; nb[0] = 40; dly[0] = 1;
    bus.req_lba0 = $urandom; bus.req_din0 = 8'($urandom);
    e.who = 1'b0; e.lba = bus.req_lba0; e.rd = 1'b1; e.wr = 1'b0; e.err = 1'b0; e.nbuf = 40; e.din = bus.req_din0;
    q.push_back(e);
    bus.req_rd = 2'b01;
    while (!(bus.sd_ack && !bus.sd_rd) && cyc < 100) begin tick; cyc++; end
    chk("reach_xfer", {bus.sd_ack, bus.sd_rd}, 2'b10);
    repeat (3) tick;
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    bus.req_rd = '0;
    cyc = 0;
    while (bus.sd_ack && cyc < 100) begin tick; cyc++; end
    tick;
    reset_n = 1'b1;
    rr_m = 1'b1;
    repeat (4) tick;
  endtask
  initial begin
    bus.req_rd = '0; bus.req_wr = '0; bus.req_lba0 = '0; bus.req_lba1 = '0;
    bus.req_din0 = '0; bus.req_din1 = '0;
    #1 reset_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    round(2'b01, 2'b01, 2'b00, 2'b11, 512, 32'h10);
    round(2'b10, 2'b10, 2'b10, 2'b11, 4, $urandom);
    for (int r = 0; r < 4; r++) round(2'b11, 2'($urandom), 2'b11, 2'b11, 3, $urandom);
    for (int r = 0; r < 40; r++) begin
      automatic logic [1:0] rd = 2'($urandom);
      automatic logic [1:0] ack = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      round(2'($urandom_range(1, 3)), rd, ~rd | 2'($urandom), ack, $urandom_range(1, 16), $urandom);
    end
    round(2'b01, 2'b01, 2'b00, 2'b00, 1, $urandom);
    reset_mid_xfer;
    round(2'b11, 2'b00, 2'b11, 2'b11, 8, $urandom);
    repeat (4) tick;
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL sim_timeout: run did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
